// File: rtl/osd_regs_pkg.sv
// Shared definitions for the OSD register bank: register offsets, field positions,
// commit FSM encoding and the live-overlay struct. Optional feature macro: OSD_IRQ_EN.
package osd_regs_pkg;

  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_POS       = 8'h04;
  localparam logic [7:0] OFF_COLOR     = 8'h08;
  localparam logic [7:0] OFF_STATUS    = 8'h0C;
  localparam logic [7:0] OFF_FRAME_CNT = 8'h10;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h14;
  localparam logic [7:0] OFF_VERSION   = 8'h18;
  localparam logic [7:0] OFF_TEXT_PTR  = 8'h1C;
  localparam logic [7:0] OFF_TEXT_DATA = 8'h20;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_COMMIT_BIT   = 1;
  localparam int STATUS_PEND_BIT   = 0;
  localparam int STATUS_FDONE_BIT  = 1;
  localparam int IRQ_EN_FDONE_BIT  = 1;

  localparam int POS_W   = 16;
  localparam int COLOR_W = 24;
  localparam int ALPHA_W = 8;

  localparam logic [31:0] VERSION_DEFAULT = 32'h0001_0000;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic               en;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
    logic [COLOR_W-1:0] color;
    logic [ALPHA_W-1:0] alpha;
  } osd_live_t;

endpackage

// File: rtl/osd_shadow_ctrl.sv
// Commit FSM for the OSD overlay: a commit request arms PENDING, and the next frame start
// copies the staging set into the live set. Current state is exposed on o_state.
module osd_shadow_ctrl
  import osd_regs_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_commit,
  input  logic          i_frame_start,
  input  osd_live_t     i_stage,
  output osd_live_t     o_live,
  output logic          o_pending,
  output commit_state_t o_state
);

  commit_state_t r_state;
  osd_live_t     r_live;

  // A commit arriving together with a frame start only arms the FSM; the copy
  // waits for the following frame start so the frame sees a consistent set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_commit) r_state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (i_frame_start) begin
            r_live  <= i_stage;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_live    = r_live;
  assign o_pending = (r_state == ST_PENDING);
  assign o_state   = r_state;

endmodule

// File: rtl/osd_reg_bank.sv
// OSD register bank behind the AXI4-Lite adapter: staging/live overlay registers, frame counter,
// W1C frame_done status and an auto-incrementing text RAM write port. Macro OSD_IRQ_EN adds IRQ_EN/irq_o.
module osd_reg_bank
  import osd_regs_pkg::*;
#(
  parameter int          TEXT_AW = 8,
  parameter int          DEC_W   = 8,
  parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               mem_wr_valid,
  input  logic [31:0]        mem_wr_addr,
  input  logic [31:0]        mem_wr_data,
  input  logic [31:0]        mem_rd_addr,
  output logic [31:0]        mem_rd_data,
  input  logic               frame_start_i,
  output logic               osd_en_o,
  output logic [15:0]        osd_x_o,
  output logic [15:0]        osd_y_o,
  output logic [23:0]        osd_color_o,
  output logic [7:0]         osd_alpha_o,
  output logic               text_we_o,
  output logic [TEXT_AW-1:0] text_addr_o,
  output logic [31:0]        text_data_o,
  output logic               irq_o
);

  logic [DEC_W-1:0] w_wr_off;
  logic [DEC_W-1:0] w_rd_off;
  logic             w_wr_ctrl;
  logic             w_wr_pos;
  logic             w_wr_color;
  logic             w_wr_status;
  logic             w_wr_tptr;
  logic             w_wr_tdata;
  logic             w_commit;
  logic             w_pending;
  logic             w_irq_en;
  logic [31:0]      w_rd_data;
  osd_live_t        w_live;
  commit_state_t    w_commit_state;
  logic             w_unused;

  osd_live_t          r_stage;
  logic [31:0]        r_frame_cnt;
  logic               r_frame_done;
  logic [TEXT_AW-1:0] r_text_ptr;
  logic               r_text_we;
  logic [TEXT_AW-1:0] r_text_addr;
  logic [31:0]        r_text_data;

  assign w_wr_off    = mem_wr_addr[DEC_W-1:0];
  assign w_rd_off    = mem_rd_addr[DEC_W-1:0];
  assign w_wr_ctrl   = mem_wr_valid && (w_wr_off == DEC_W'(OFF_CTRL));
  assign w_wr_pos    = mem_wr_valid && (w_wr_off == DEC_W'(OFF_POS));
  assign w_wr_color  = mem_wr_valid && (w_wr_off == DEC_W'(OFF_COLOR));
  assign w_wr_status = mem_wr_valid && (w_wr_off == DEC_W'(OFF_STATUS));
  assign w_wr_tptr   = mem_wr_valid && (w_wr_off == DEC_W'(OFF_TEXT_PTR));
  assign w_wr_tdata  = mem_wr_valid && (w_wr_off == DEC_W'(OFF_TEXT_DATA));
  assign w_commit    = w_wr_ctrl && mem_wr_data[CTRL_COMMIT_BIT];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_stage      <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_text_ptr   <= '0;
      r_text_we    <= 1'b0;
      r_text_addr  <= '0;
      r_text_data  <= '0;
    end else begin
      if (w_wr_ctrl) r_stage.en <= mem_wr_data[CTRL_EN_BIT];
      if (w_wr_pos) begin
        r_stage.x <= mem_wr_data[15:0];
        r_stage.y <= mem_wr_data[31:16];
      end
      if (w_wr_color) begin
        r_stage.color <= mem_wr_data[23:0];
        r_stage.alpha <= mem_wr_data[31:24];
      end
      if (frame_start_i) r_frame_cnt <= r_frame_cnt + 32'd1;
      // A new frame outranks a software clear landing on the same edge.
      if (frame_start_i) begin
        r_frame_done <= 1'b1;
      end else if (w_wr_status && mem_wr_data[STATUS_FDONE_BIT]) begin
        r_frame_done <= 1'b0;
      end
      r_text_we <= w_wr_tdata;
      if (w_wr_tdata) begin
        r_text_addr <= r_text_ptr;
        r_text_data <= mem_wr_data;
        r_text_ptr  <= r_text_ptr + TEXT_AW'(1);
      end else if (w_wr_tptr) begin
        r_text_ptr <= mem_wr_data[TEXT_AW-1:0];
      end
    end
  end

`ifdef OSD_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (mem_wr_valid && (w_wr_off == DEC_W'(OFF_IRQ_EN))) begin
        r_irq_en <= mem_wr_data[IRQ_EN_FDONE_BIT];
      end
      r_irq <= r_frame_done && r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq_o    = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq_o    = 1'b0;
`endif

  osd_shadow_ctrl u_shadow (
    .i_clk         (aclk),
    .i_rst_n       (aresetn),
    .i_commit      (w_commit),
    .i_frame_start (frame_start_i),
    .i_stage       (r_stage),
    .o_live        (w_live),
    .o_pending     (w_pending),
    .o_state       (w_commit_state)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_rd_off)
      DEC_W'(OFF_CTRL):      w_rd_data[CTRL_EN_BIT] = r_stage.en;
      DEC_W'(OFF_POS):       w_rd_data = {r_stage.y, r_stage.x};
      DEC_W'(OFF_COLOR):     w_rd_data = {r_stage.alpha, r_stage.color};
      DEC_W'(OFF_STATUS): begin
        w_rd_data[STATUS_PEND_BIT]  = w_pending;
        w_rd_data[STATUS_FDONE_BIT] = r_frame_done;
      end
      DEC_W'(OFF_FRAME_CNT): w_rd_data = r_frame_cnt;
`ifdef OSD_IRQ_EN
      DEC_W'(OFF_IRQ_EN):    w_rd_data[IRQ_EN_FDONE_BIT] = w_irq_en;
`endif
      DEC_W'(OFF_VERSION):   w_rd_data = VERSION;
      DEC_W'(OFF_TEXT_PTR):  w_rd_data[TEXT_AW-1:0] = r_text_ptr;
      default:               w_rd_data = '0;
    endcase
  end

  assign mem_rd_data = w_rd_data;
  assign osd_en_o    = w_live.en;
  assign osd_x_o     = w_live.x;
  assign osd_y_o     = w_live.y;
  assign osd_color_o = w_live.color;
  assign osd_alpha_o = w_live.alpha;
  assign text_we_o   = r_text_we;
  assign text_addr_o = r_text_addr;
  assign text_data_o = r_text_data;

  assign w_unused = &{1'b0, mem_wr_addr[31:DEC_W], mem_rd_addr[31:DEC_W], w_commit_state, w_irq_en};

endmodule
